sram_access_ctrl: RTL and testbench

//  Memory-side responder for the SNES address decoder. It takes the decoded
//  ROM_ADDR, ROM_HIT and IS_WRITABLE for each SNES bus cycle and runs the

---
 rtl/sram_access_ctrl_if.sv | 48 ++++
 rtl/sram_access_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Bus bundle between the SNES address decoder / MCU side and the SRAM0
// access controller, including the external SRAM0 pin group.
interface sram_access_ctrl_if;
  // SNES side
  logic        SNES_RD_start;
  logic        SNES_WR_start;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT;
  logic        IS_WRITABLE;
  logic [7:0]  SNES_DATA_IN;
  logic [7:0]  SNES_DATA_OUT;
  logic        snes_rd_valid;
  // MCU side
  logic        MCU_RRQ;
  logic        MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT;
  logic [7:0]  MCU_DINr;
  logic        MCU_RDY;
  // SRAM0 pins
  logic [23:0] SRAM_ADDR;
  logic [7:0]  SRAM_DATA_OUT;
  logic        SRAM_DATA_OE;
  logic [7:0]  SRAM_DATA_IN;
  logic        SRAM_CEn;
  logic        SRAM_OEn;
  logic        SRAM_WEn;

  // Requesters and the SRAM device model
  modport master (
    output SNES_RD_start, SNES_WR_start, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
    input  SNES_DATA_OUT, snes_rd_valid,
    output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT,
    input  MCU_DINr, MCU_RDY,
    input  SRAM_ADDR, SRAM_DATA_OUT, SRAM_DATA_OE, SRAM_CEn, SRAM_OEn, SRAM_WEn,
    output SRAM_DATA_IN
  );

  // The access controller
  modport slave (
    input  SNES_RD_start, SNES_WR_start, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
    output SNES_DATA_OUT, snes_rd_valid,
    input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT,
    output MCU_DINr, MCU_RDY,
    output SRAM_ADDR, SRAM_DATA_OUT, SRAM_DATA_OE, SRAM_CEn, SRAM_OEn, SRAM_WEn,
    input  SRAM_DATA_IN
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM0 access controller: latches qualified SNES and MCU requests into one
// pending slot each, then runs timed read/write strobe sequences on the
// external SRAM, SNES first, with a recovery gap after every access.
module sram_access_ctrl #(
  parameter int RD_WAIT = 4,
  parameter int WR_WAIT = 4,
  parameter int REC_CYC = 1
) (
  input logic               CLK,
  input logic               RST,
  sram_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SNES_RD, SNES_WR, MCU_RD, MCU_WR, RECOVER} state_t;

  state_t      state, state_nx;
  logic [3:0]  wait_cnt, wait_nx;
  logic [1:0]  rec_cnt, rec_nx;

  // pending slots (type, address, data)
  logic        snes_pend, snes_pend_wr;
  logic [23:0] snes_pend_addr;
  logic [7:0]  snes_pend_data;
  logic        mcu_pend, mcu_pend_wr;
  logic [23:0] mcu_pend_addr;
  logic [7:0]  mcu_pend_data;

  // registered outputs and their next values
  logic [23:0] sram_addr, addr_nx;
  logic [7:0]  sram_dout, dout_nx;
  logic        data_oe, data_oe_nx;
  logic        ce_n, ce_nx, oe_n, oe_nx, we_n, we_nx;
  logic [7:0]  snes_dout, snes_dout_nx;
  logic        snes_valid, snes_valid_nx;
  logic [7:0]  mcu_din, mcu_din_nx;
  logic        mcu_rdy, mcu_rdy_nx;

  logic        snes_rd_acc, snes_wr_acc, mcu_acc, snes_take, mcu_take;

  // Request qualification: writes need a writable target, MCU needs to be idle.
  assign snes_rd_acc = bus.SNES_RD_start & bus.ROM_HIT;
  assign snes_wr_acc = bus.SNES_WR_start & bus.ROM_HIT & bus.IS_WRITABLE;
  assign mcu_acc     = (bus.MCU_RRQ | bus.MCU_WRQ) & mcu_rdy;

  // Next-state, strobe and capture logic.
  always_comb begin
    state_nx      = state;
    wait_nx       = wait_cnt;
    rec_nx        = rec_cnt;
    addr_nx       = sram_addr;
    dout_nx       = sram_dout;
    ce_nx         = 1'b1;
    oe_nx         = 1'b1;
    we_nx         = 1'b1;
    snes_dout_nx  = snes_dout;
    snes_valid_nx = 1'b0;
    mcu_din_nx    = mcu_din;
    mcu_rdy_nx    = mcu_rdy & ~mcu_acc;
    snes_take     = 1'b0;
    mcu_take      = 1'b0;
    case (state)
      IDLE: begin
        if (snes_pend) begin
          snes_take = 1'b1;
          addr_nx   = snes_pend_addr;
          ce_nx     = 1'b0;
          if (snes_pend_wr) begin
            state_nx = SNES_WR;
            we_nx    = 1'b0;
            dout_nx  = snes_pend_data;
            wait_nx  = 4'(WR_WAIT - 1);
          end else begin
            state_nx = SNES_RD;
            oe_nx    = 1'b0;
            wait_nx  = 4'(RD_WAIT - 1);
          end
        end else if (mcu_pend) begin
          mcu_take = 1'b1;
          addr_nx  = mcu_pend_addr;
          ce_nx    = 1'b0;
          if (mcu_pend_wr) begin
            state_nx = MCU_WR;
            we_nx    = 1'b0;
            dout_nx  = mcu_pend_data;
            wait_nx  = 4'(WR_WAIT - 1);
          end else begin
            state_nx = MCU_RD;
            oe_nx    = 1'b0;
            wait_nx  = 4'(RD_WAIT - 1);
          end
        end else begin
          state_nx = IDLE;
        end
      end
      SNES_RD, MCU_RD: begin
        if (wait_cnt == 4'd0) begin
          state_nx = RECOVER;
          rec_nx   = 2'(REC_CYC - 1);
          if (state == SNES_RD) begin
            snes_dout_nx  = bus.SRAM_DATA_IN;
            snes_valid_nx = 1'b1;
          end else begin
            mcu_din_nx = bus.SRAM_DATA_IN;
            mcu_rdy_nx = 1'b1;
          end
        end else begin
          ce_nx   = 1'b0;
          oe_nx   = 1'b0;
          wait_nx = wait_cnt - 4'd1;
        end
      end
      SNES_WR, MCU_WR: begin
        if (wait_cnt == 4'd0) begin
          state_nx = RECOVER;
          rec_nx   = 2'(REC_CYC - 1);
          if (state == MCU_WR) begin
            mcu_rdy_nx = 1'b1;
          end else begin
            mcu_rdy_nx = mcu_rdy & ~mcu_acc;
          end
        end else begin
          ce_nx   = 1'b0;
          we_nx   = 1'b0;
          wait_nx = wait_cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (rec_cnt == 2'd0) begin
          state_nx = IDLE;
        end else begin
          rec_nx = rec_cnt - 2'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    // data bus stays driven for one cycle after WEn rises (hold time)
    data_oe_nx = (state_nx == SNES_WR) | (state_nx == MCU_WR) |
                 (state == SNES_WR) | (state == MCU_WR);
  end

  // State register and registered SRAM/requester outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      rec_cnt    <= 2'd0;
      sram_addr  <= 24'h000000;
      sram_dout  <= 8'h00;
      data_oe    <= 1'b0;
      ce_n       <= 1'b1;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      snes_dout  <= 8'h00;
      snes_valid <= 1'b0;
      mcu_din    <= 8'h00;
      mcu_rdy    <= 1'b1;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_nx;
      rec_cnt    <= rec_nx;
      sram_addr  <= addr_nx;
      sram_dout  <= dout_nx;
      data_oe    <= data_oe_nx;
      ce_n       <= ce_nx;
      oe_n       <= oe_nx;
      we_n       <= we_nx;
      snes_dout  <= snes_dout_nx;
      snes_valid <= snes_valid_nx;
      mcu_din    <= mcu_din_nx;
      mcu_rdy    <= mcu_rdy_nx;
    end
  end

  // Pending slots: a new SNES start overwrites, a served entry is cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snes_pend      <= 1'b0;
      snes_pend_wr   <= 1'b0;
      snes_pend_addr <= 24'h000000;
      snes_pend_data <= 8'h00;
      mcu_pend       <= 1'b0;
      mcu_pend_wr    <= 1'b0;
      mcu_pend_addr  <= 24'h000000;
      mcu_pend_data  <= 8'h00;
    end else begin
      if (snes_rd_acc | snes_wr_acc) begin
        snes_pend      <= 1'b1;
        snes_pend_wr   <= snes_wr_acc;
        snes_pend_addr <= bus.ROM_ADDR;
        snes_pend_data <= bus.SNES_DATA_IN;
      end else if (snes_take) begin
        snes_pend <= 1'b0;
      end
      if (mcu_acc) begin
        mcu_pend      <= 1'b1;
        mcu_pend_wr   <= bus.MCU_WRQ;
        mcu_pend_addr <= bus.MCU_ADDR;
        mcu_pend_data <= bus.MCU_DOUT;
      end else if (mcu_take) begin
        mcu_pend <= 1'b0;
      end
    end
  end

  assign bus.SRAM_ADDR     = sram_addr;
  assign bus.SRAM_DATA_OUT = sram_dout;
  assign bus.SRAM_DATA_OE  = data_oe;
  assign bus.SRAM_CEn      = ce_n;
  assign bus.SRAM_OEn      = oe_n;
  assign bus.SRAM_WEn      = we_n;
  assign bus.SNES_DATA_OUT = snes_dout;
  assign bus.snes_rd_valid = snes_valid;
  assign bus.MCU_DINr      = mcu_din;
  assign bus.MCU_RDY       = mcu_rdy;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (RD_WAIT=4, WR_WAIT=4, REC_CYC=1).
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_sram_access_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  sram_access_ctrl_if bus();

  sram_access_ctrl #(.RD_WAIT(4), .WR_WAIT(4), .REC_CYC(1)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    bus.SNES_RD_start = 1'b0;
    bus.SNES_WR_start = 1'b0;
    bus.MCU_RRQ       = 1'b0;
    bus.MCU_WRQ       = 1'b0;
  endtask

  int ce_low;

  initial begin
    idle_inputs();
    bus.ROM_ADDR     = 24'h000000;
    bus.ROM_HIT      = 1'b0;
    bus.IS_WRITABLE  = 1'b0;
    bus.SNES_DATA_IN = 8'h00;
    bus.MCU_ADDR     = 24'h000000;
    bus.MCU_DOUT     = 8'h00;
    bus.SRAM_DATA_IN = 8'h00;

    // reset state
    tick(); tick();
    RST = 1'b0;
    chk("rst_cen", 32'(bus.SRAM_CEn), 32'd1);
    chk("rst_oen", 32'(bus.SRAM_OEn), 32'd1);
    chk("rst_wen", 32'(bus.SRAM_WEn), 32'd1);
    chk("rst_doe", 32'(bus.SRAM_DATA_OE), 32'd0);
    chk("rst_addr", 32'(bus.SRAM_ADDR), 32'h0);
    chk("rst_snes_do", 32'(bus.SNES_DATA_OUT), 32'h0);
    chk("rst_mcu_din", 32'(bus.MCU_DINr), 32'h0);
    chk("rst_valid", 32'(bus.snes_rd_valid), 32'd0);
    chk("rst_rdy", 32'(bus.MCU_RDY), 32'd1);

    // 1: SNES read 0x012345 -> 0xA5
    bus.SNES_RD_start = 1'b1; bus.ROM_HIT = 1'b1; bus.ROM_ADDR = 24'h012345;
    bus.SRAM_DATA_IN = 8'hA5;
    tick(); idle_inputs();
    chk("t1_oen_k", 32'(bus.SRAM_OEn), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t1_oen_low", 32'(bus.SRAM_OEn), 32'd0);
      chk("t1_addr", 32'(bus.SRAM_ADDR), 32'h012345);
    end
    tick();
    chk("t1_oen_rel", 32'(bus.SRAM_OEn), 32'd1);
    chk("t1_valid", 32'(bus.snes_rd_valid), 32'd1);
    chk("t1_data", 32'(bus.SNES_DATA_OUT), 32'hA5);
    tick();
    chk("t1_valid_end", 32'(bus.snes_rd_valid), 32'd0);

    // 2a: write to non-writable area is ignored
    bus.SNES_WR_start = 1'b1; bus.IS_WRITABLE = 1'b0; bus.ROM_ADDR = 24'h008000;
    bus.SNES_DATA_IN = 8'h3C;
    tick(); idle_inputs();
    ce_low = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.SRAM_CEn == 1'b0 || bus.SRAM_WEn == 1'b0) ce_low++;
    end
    chk("t2_ignored", 32'(ce_low), 32'd0);

    // 2b: write 0x3C to save RAM 0xE00010
    bus.SNES_WR_start = 1'b1; bus.IS_WRITABLE = 1'b1; bus.ROM_ADDR = 24'hE00010;
    tick(); idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_wen_low", 32'(bus.SRAM_WEn), 32'd0);
      chk("t2_doe", 32'(bus.SRAM_DATA_OE), 32'd1);
    end
    chk("t2_addr", 32'(bus.SRAM_ADDR), 32'hE00010);
    chk("t2_wdata", 32'(bus.SRAM_DATA_OUT), 32'h3C);
    tick();
    chk("t2_wen_rel", 32'(bus.SRAM_WEn), 32'd1);
    chk("t2_doe_hold", 32'(bus.SRAM_DATA_OE), 32'd1);
    tick();
    chk("t2_doe_off", 32'(bus.SRAM_DATA_OE), 32'd0);

    // 3: simultaneous SNES read (0x000010) and MCU write (0x100000, 0x77)
    bus.SNES_RD_start = 1'b1; bus.ROM_ADDR = 24'h000010; bus.SRAM_DATA_IN = 8'h5A;
    bus.MCU_WRQ = 1'b1; bus.MCU_ADDR = 24'h100000; bus.MCU_DOUT = 8'h77;
    tick(); idle_inputs();
    chk("t3_rdy_drop", 32'(bus.MCU_RDY), 32'd0);
    tick();
    chk("t3_snes_first", 32'(bus.SRAM_ADDR), 32'h000010);
    chk("t3_snes_oen", 32'(bus.SRAM_OEn), 32'd0);
    tick(); tick(); tick(); tick();
    chk("t3_snes_data", 32'(bus.SNES_DATA_OUT), 32'h5A);
    chk("t3_rdy_wait", 32'(bus.MCU_RDY), 32'd0);
    tick(); tick();
    chk("t3_mcu_addr", 32'(bus.SRAM_ADDR), 32'h100000);
    chk("t3_mcu_wen", 32'(bus.SRAM_WEn), 32'd0);
    chk("t3_mcu_wdata", 32'(bus.SRAM_DATA_OUT), 32'h77);
    tick(); tick(); tick();
    chk("t3_rdy_late", 32'(bus.MCU_RDY), 32'd0);
    tick();
    chk("t3_rdy_up", 32'(bus.MCU_RDY), 32'd1);
    chk("t3_wen_rel", 32'(bus.SRAM_WEn), 32'd1);
    tick();

    // 4: SNES read arriving during an MCU read (0x200000 -> 0xC3)
    bus.MCU_RRQ = 1'b1; bus.MCU_ADDR = 24'h200000; bus.SRAM_DATA_IN = 8'hC3;
    tick(); idle_inputs();
    tick();
    chk("t4_mcu_addr", 32'(bus.SRAM_ADDR), 32'h200000);
    bus.SNES_RD_start = 1'b1; bus.ROM_ADDR = 24'h000020;
    tick(); idle_inputs();
    chk("t4_no_abort", 32'(bus.SRAM_ADDR), 32'h200000);
    tick(); tick(); tick();
    chk("t4_mcu_din", 32'(bus.MCU_DINr), 32'hC3);
    chk("t4_mcu_rdy", 32'(bus.MCU_RDY), 32'd1);
    bus.SRAM_DATA_IN = 8'h96;
    tick();
    chk("t4_recover", 32'(bus.SRAM_CEn), 32'd1);
    tick();
    chk("t4_snes_addr", 32'(bus.SRAM_ADDR), 32'h000020);
    chk("t4_snes_oen", 32'(bus.SRAM_OEn), 32'd0);
    tick(); tick(); tick(); tick();
    chk("t4_snes_valid", 32'(bus.snes_rd_valid), 32'd1);
    chk("t4_snes_data", 32'(bus.SNES_DATA_OUT), 32'h96);
    tick();

    // 5: reset on the 2nd WEn-low cycle, with SNES and MCU requests pending
    bus.SNES_WR_start = 1'b1; bus.ROM_ADDR = 24'hE00040; bus.SNES_DATA_IN = 8'h11;
    tick(); idle_inputs();
    tick();
    bus.SNES_RD_start = 1'b1; bus.ROM_ADDR = 24'h000030;
    bus.MCU_RRQ = 1'b1; bus.MCU_ADDR = 24'h400000;
    tick(); idle_inputs();
    chk("t5_wen_2nd", 32'(bus.SRAM_WEn), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t5_wen", 32'(bus.SRAM_WEn), 32'd1);
    chk("t5_cen", 32'(bus.SRAM_CEn), 32'd1);
    chk("t5_doe", 32'(bus.SRAM_DATA_OE), 32'd0);
    chk("t5_rdy", 32'(bus.MCU_RDY), 32'd1);
    ce_low = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.SRAM_CEn == 1'b0) ce_low++;
    end
    chk("t5_no_pending", 32'(ce_low), 32'd0);

    // 6: two SNES reads 2 cycles apart during an MCU write
    bus.MCU_WRQ = 1'b1; bus.MCU_ADDR = 24'h300000; bus.MCU_DOUT = 8'h55;
    bus.SRAM_DATA_IN = 8'hE7;
    tick(); idle_inputs();
    tick();
    bus.SNES_RD_start = 1'b1; bus.ROM_ADDR = 24'h000100;
    tick(); idle_inputs();
    tick();
    bus.SNES_RD_start = 1'b1; bus.ROM_ADDR = 24'h000200;
    tick(); idle_inputs();
    tick();
    chk("t6_mcu_done", 32'(bus.MCU_RDY), 32'd1);
    tick(); tick();
    chk("t6_second_addr", 32'(bus.SRAM_ADDR), 32'h000200);
    chk("t6_oen", 32'(bus.SRAM_OEn), 32'd0);
    tick(); tick(); tick(); tick();
    chk("t6_data", 32'(bus.SNES_DATA_OUT), 32'hE7);
    ce_low = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.SRAM_CEn == 1'b0) ce_low++;
    end
    chk("t6_single_read", 32'(ce_low), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
